// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard/forwarding unit.
// HAZARD_MUL_EN adds the is_mul slot field.
package definitions;

  typedef logic       Signal;
  typedef logic [4:0] RegAddr;

  typedef struct packed {
    Signal  valid;
    RegAddr rd;
    Signal  reg_write;
    Signal  is_load;
`ifdef HAZARD_MUL_EN
    Signal  is_mul;
`endif
  } HzSlot;

  typedef enum logic {
    HZ_IDLE,
    HZ_BUSY
  } HzState;

  localparam HzSlot HZ_BUBBLE = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Per-source tag compare against the X and M
// shadow slots. Register zero never matches.
module hazard_cmp
  import definitions::*;
(
  input  HzSlot  x_i,
  input  HzSlot  m_i,
  input  Signal  dx_valid_i,
  input  RegAddr addr_i,
  input  Signal  use_i,
  output Signal  hit_x_o,
  output Signal  hit_m_o,
  output Signal  x_load_o
);

  Signal req;

  assign req = dx_valid_i && use_i &&
               (addr_i != '0);

  assign hit_x_o = req && x_i.valid &&
                   x_i.reg_write &&
                   (x_i.rd == addr_i);

  assign hit_m_o = req && m_i.valid &&
                   m_i.reg_write &&
                   (m_i.rd == addr_i);

  assign x_load_o = x_i.is_load;

  Signal unused_fields;
`ifdef HAZARD_MUL_EN
  assign unused_fields = ^{m_i.is_load,
                           m_i.is_mul,
                           x_i.is_mul};
`else
  assign unused_fields = m_i.is_load;
`endif

endmodule

// File: rtl/hazard_unit.sv
// Load-use / multiply-busy stall and forwarding
// select generation. HAZARD_MUL_EN enables the mul FSM.
module hazard_unit
  import definitions::*;
#(
  parameter int MUL_LAT = 4
) (
  input  Signal  clk,
  input  Signal  rst_n,
  input  Signal  dx_valid,
  input  RegAddr dx_rs_addr,
  input  RegAddr dx_rt_addr,
  input  Signal  dx_uses_rs,
  input  Signal  dx_uses_rt,
  input  RegAddr dx_rd_addr,
  input  Signal  dx_reg_write,
  input  Signal  dx_mem_read,
  input  Signal  dx_mul,
  output Signal  stall,
  output Signal  fwdX_rs,
  output Signal  fwdX_rt,
  output Signal  fwdM_rs,
  output Signal  fwdM_rt
);

  HzSlot x_q, x_d;
  HzSlot m_q, m_d;
  HzSlot dx_slot;

  Signal hx_rs, hm_rs, xl_rs;
  Signal hx_rt, hm_rt, xl_rt;
  Signal load_stall;
  Signal fx_rs, fx_rt;
  Signal fm_rs, fm_rt;

  always_comb begin
    dx_slot           = HZ_BUBBLE;
    dx_slot.valid     = dx_valid;
    dx_slot.rd        = dx_rd_addr;
    dx_slot.reg_write = dx_reg_write;
    dx_slot.is_load   = dx_mem_read;
`ifdef HAZARD_MUL_EN
    dx_slot.is_mul    = dx_mul;
`endif
  end

  hazard_cmp u_cmp_rs (
    .x_i        (x_q),
    .m_i        (m_q),
    .dx_valid_i (dx_valid),
    .addr_i     (dx_rs_addr),
    .use_i      (dx_uses_rs),
    .hit_x_o    (hx_rs),
    .hit_m_o    (hm_rs),
    .x_load_o   (xl_rs)
  );

  hazard_cmp u_cmp_rt (
    .x_i        (x_q),
    .m_i        (m_q),
    .dx_valid_i (dx_valid),
    .addr_i     (dx_rt_addr),
    .use_i      (dx_uses_rt),
    .hit_x_o    (hx_rt),
    .hit_m_o    (hm_rt),
    .x_load_o   (xl_rt)
  );

  assign load_stall = (hx_rs && xl_rs) ||
                      (hx_rt && xl_rt);

  assign fx_rs = hx_rs && !xl_rs;
  assign fx_rt = hx_rt && !xl_rt;
  assign fm_rs = hm_rs && !fx_rs;
  assign fm_rt = hm_rt && !fx_rt;

  assign fwdX_rs = fx_rs && !stall;
  assign fwdX_rt = fx_rt && !stall;
  assign fwdM_rs = fm_rs && !stall;
  assign fwdM_rt = fm_rt && !stall;

`ifdef HAZARD_MUL_EN
  localparam int CW = $clog2(MUL_LAT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_INIT = cnt_t'(MUL_LAT - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  HzState state_q, state_d;
  cnt_t    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
      x_q     <= HZ_BUBBLE;
      m_q     <= HZ_BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    m_d     = m_q;
    unique case (state_q)
      HZ_IDLE: begin
        m_d = x_q;
        x_d = load_stall ? HZ_BUBBLE : dx_slot;
        if (dx_valid && dx_mul && !load_stall) begin
          state_d = HZ_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      HZ_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        m_d   = HZ_BUBBLE;
        // Successor is still held in DX, so X
        // takes a bubble as the mul drops to M.
        if (cnt_q == CNT_ONE) begin
          state_d = HZ_IDLE;
          m_d     = x_q;
          x_d     = HZ_BUBBLE;
        end
      end
      default: begin
        state_d = HZ_IDLE;
      end
    endcase
  end

  always_comb begin
    stall = load_stall;
    if (state_q == HZ_BUSY) stall = 1'b1;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= HZ_BUBBLE;
      m_q <= HZ_BUBBLE;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
    end
  end

  always_comb begin
    m_d = x_q;
    x_d = load_stall ? HZ_BUBBLE : dx_slot;
  end

  assign stall = load_stall;

  Signal unused_cfg;
  assign unused_cfg = dx_mul ^ (MUL_LAT > 0);
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MUL_LAT=4).
// Mul sequences run when HAZARD_MUL_EN is defined.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dx_valid;
  logic [4:0] dx_rs_addr, dx_rt_addr;
  logic       dx_uses_rs, dx_uses_rt;
  logic [4:0] dx_rd_addr;
  logic       dx_reg_write, dx_mem_read, dx_mul;
  logic       stall;
  logic       fwdX_rs, fwdX_rt;
  logic       fwdM_rs, fwdM_rt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_unit #(.MUL_LAT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dx_valid     (dx_valid),
    .dx_rs_addr   (dx_rs_addr),
    .dx_rt_addr   (dx_rt_addr),
    .dx_uses_rs   (dx_uses_rs),
    .dx_uses_rt   (dx_uses_rt),
    .dx_rd_addr   (dx_rd_addr),
    .dx_reg_write (dx_reg_write),
    .dx_mem_read  (dx_mem_read),
    .dx_mul       (dx_mul),
    .stall        (stall),
    .fwdX_rs      (fwdX_rs),
    .fwdX_rt      (fwdX_rt),
    .fwdM_rs      (fwdM_rs),
    .fwdM_rt      (fwdM_rt)
  );

  function automatic logic [4:0] outs();
    return {stall, fwdX_rs, fwdX_rt,
            fwdM_rs, fwdM_rt};
  endfunction

  task automatic check(input string tag,
                       input logic [4:0] got,
                       input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (stall,fXrs,fXrt,fMrs,fMrt)",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic urs,
                       input logic urt,
                       input logic [4:0] rd,
                       input logic rw,
                       input logic mr,
                       input logic mu);
    dx_valid     = v;
    dx_rs_addr   = rs;
    dx_rt_addr   = rt;
    dx_uses_rs   = urs;
    dx_uses_rt   = urt;
    dx_rd_addr   = rd;
    dx_reg_write = rw;
    dx_mem_read  = mr;
    dx_mul       = mu;
  endtask

  task automatic sample(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, outs(), e);
    end
  endtask

  task automatic step(input string tag,
                      input logic v,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic urs,
                      input logic urt,
                      input logic [4:0] rd,
                      input logic rw,
                      input logic mr,
                      input logic mu,
                      input logic [4:0] exp);
    drive(v, rs, rt, urs, urt, rd, rw, mr, mu);
    exp_q.push_back(exp);
    @(negedge clk);
    sample(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("reset", 1, 5, 5, 1, 1, 5, 1, 1, 0,
         5'b00000);
    rst_n = 1'b1;

    step("ld_issue", 1, 0, 0, 0, 0, 5, 1, 1, 0,
         5'b00000);
    step("ld_use", 1, 5, 0, 1, 0, 6, 1, 0, 0,
         5'b10000);
    step("ld_fwdM", 1, 5, 0, 1, 0, 6, 1, 0, 0,
         5'b00010);

    step("alu3_a", 1, 0, 0, 0, 0, 3, 1, 0, 0,
         5'b00000);
    step("alu3_b", 1, 0, 0, 0, 0, 3, 1, 0, 0,
         5'b00000);
    step("dual_fwd", 1, 3, 3, 1, 1, 7, 1, 0, 0,
         5'b01100);

    step("wr_r0", 1, 0, 0, 0, 0, 0, 1, 0, 0,
         5'b00000);
    step("rd_r0", 1, 0, 0, 1, 1, 8, 1, 0, 0,
         5'b00000);
    step("dx_inval", 0, 8, 0, 1, 0, 9, 1, 0, 0,
         5'b00000);
    step("fwdM_only", 1, 8, 0, 1, 0, 9, 1, 0, 0,
         5'b00010);
    step("no_use", 1, 9, 9, 0, 0, 0, 0, 0, 0,
         5'b00000);

`ifdef HAZARD_MUL_EN
    step("mul_issue", 1, 0, 0, 0, 0, 10, 1, 0, 1,
         5'b00000);
    for (int i = 0; i < 3; i++)
      step("mul_busy", 1, 10, 10, 1, 1, 11, 1, 0, 0,
           5'b10000);
    step("mul_rel", 1, 10, 10, 1, 1, 11, 1, 0, 0,
         5'b00011);

    step("mul2_issue", 1, 0, 0, 0, 0, 12, 1, 0, 1,
         5'b00000);
    step("mul2_busy1", 1, 12, 0, 1, 0, 15, 1, 0, 0,
         5'b10000);
    drive(1, 12, 0, 1, 0, 15, 1, 0, 0);
    exp_q.push_back(5'b10000);
    @(negedge clk);
    sample("mul2_busy2");
    #1;
    rst_n = 1'b0;
    exp_q.push_back(5'b00000);
    #1;
    sample("rst_imm");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 1, 12, 0, 1, 0, 15, 1, 0, 0,
         5'b00000);
    step("post_fwd", 1, 15, 0, 1, 0, 16, 1, 0, 0,
         5'b01000);

    step("ld13", 1, 0, 0, 0, 0, 13, 1, 1, 0,
         5'b00000);
    step("mul_lduse", 1, 13, 0, 1, 0, 14, 1, 0, 1,
         5'b10000);
    step("mul_enter", 1, 13, 0, 1, 0, 14, 1, 0, 1,
         5'b00010);
    for (int i = 0; i < 3; i++)
      step("mul3_busy", 1, 0, 0, 0, 0, 17, 1, 0, 0,
           5'b10000);
    step("mul3_rel", 1, 0, 0, 0, 0, 17, 1, 0, 0,
         5'b00000);
`else
    for (int i = 0; i < 4; i++)
      step("mul_off", 1, 0, 0, 0, 0, 10, 1, 0, 1,
           5'b00000);
    step("mul_off_ld", 1, 0, 0, 0, 0, 13, 1, 1, 1,
         5'b00000);
    step("mul_off_use", 1, 13, 0, 1, 0, 14, 1, 0, 1,
         5'b10000);
`endif

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d left, want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
